// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  typedef logic master_idx_t;

  localparam int unsigned DEPTH_WORDS_DEF = 1000;
  // Byte-offset bits inside one 64-bit word; the word index sits above them.
  localparam int unsigned WORD_OFS_W = 3;

endpackage

// File: rtl/dmem_arb_pick.sv
// Conflict resolution between the two masters, one-hot grant out.
// DMEM_ARB_RR_EN selects round-robin; otherwise master 0 has fixed priority.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

`ifdef DMEM_ARB_RR_EN
  master_idx_t last_q;
  master_idx_t last_d;

  // Grant selection: on conflict the master not granted last wins.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_q == 1'b1) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  // Pointer next state: follows every grant issued while idle.
  always_comb begin
    last_d = last_q;
    if (upd_i && (gnt_o != 2'b00)) begin
      last_d = gnt_o[1];
    end else begin
      last_d = last_q;
    end
  end

  // Pointer register; reset value makes master 0 win the first conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{clk, rst, upd_i};

  // Grant selection: master 0 always wins a conflict.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer for the single-port data memory with lock
// sequences and address checking. Conflict policy: see DMEM_ARB_RR_EN in dmem_arb_pick.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m0_err,
  output logic              m1_err,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  output logic              mem_WE,
  input  logic [DATA_W-1:0] mem_RD
);

  localparam int unsigned IDX_W = ADDR_W - WORD_OFS_W;
  localparam logic [IDX_W-1:0] DEPTH_L = IDX_W'(DEPTH_WORDS);

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic [1:0]        pick_gnt_s;
  logic [1:0]        gnt_s;
  logic              any_gnt_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] wdata_s;
  logic              we_s;
  logic              lock_s;
  logic              err_s;
  logic [DATA_W-1:0] rd_s;

  logic [1:0]        rvalid_q, rvalid_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  dmem_arb_pick u_pick (
    .clk   (clk),
    .rst   (rst),
    .req_i ({m1_req, m0_req}),
    .upd_i (state_q == IDLE),
    .gnt_o (pick_gnt_s)
  );

  // Grant: the picker decides while idle, a lock owner is served exclusively.
  always_comb begin
    gnt_s = 2'b00;
    case (state_q)
      IDLE:    gnt_s = pick_gnt_s;
      LOCK0:   gnt_s = {1'b0, m0_req};
      LOCK1:   gnt_s = {m1_req, 1'b0};
      default: gnt_s = 2'b00;
    endcase
  end

  assign any_gnt_s = |gnt_s;
  assign m0_gnt    = gnt_s[0];
  assign m1_gnt    = gnt_s[1];

  // Granted-access mux and address check; full-width compare so high bits cannot alias.
  always_comb begin
    addr_s  = {ADDR_W{1'b0}};
    wdata_s = {DATA_W{1'b0}};
    we_s    = 1'b0;
    lock_s  = 1'b0;
    if (gnt_s[1]) begin
      addr_s  = m1_addr;
      wdata_s = m1_wdata;
      we_s    = m1_we;
      lock_s  = m1_lock;
    end else if (gnt_s[0]) begin
      addr_s  = m0_addr;
      wdata_s = m0_wdata;
      we_s    = m0_we;
      lock_s  = m0_lock;
    end else begin
      addr_s  = {ADDR_W{1'b0}};
      wdata_s = {DATA_W{1'b0}};
      we_s    = 1'b0;
      lock_s  = 1'b0;
    end
    err_s = any_gnt_s &&
            ((addr_s[WORD_OFS_W-1:0] != {WORD_OFS_W{1'b0}}) ||
             (addr_s[ADDR_W-1:WORD_OFS_W] >= DEPTH_L));
  end

  assign mem_A  = addr_s;
  assign mem_WD = wdata_s;
  assign mem_WE = any_gnt_s & we_s & ~err_s;

  // Lock sequencing: ownership is released as soon as the owner drops lock.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_gnt_s && lock_s) begin
          state_d = gnt_s[1] ? LOCK1 : LOCK0;
        end else begin
          state_d = IDLE;
        end
      end
      LOCK0:   state_d = m0_lock ? LOCK0 : IDLE;
      LOCK1:   state_d = m1_lock ? LOCK1 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response next state: only loads that pass the check carry memory data.
  always_comb begin
    rd_s       = (any_gnt_s && !we_s && !err_s) ? mem_RD : {DATA_W{1'b0}};
    rvalid_d   = gnt_s;
    err_d      = gnt_s & {2{err_s}};
    m0_rdata_d = gnt_s[0] ? rd_s : {DATA_W{1'b0}};
    m1_rdata_d = gnt_s[1] ? rd_s : {DATA_W{1'b0}};
  end

  // State and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rvalid_q   <= 2'b00;
      err_q      <= 2'b00;
      m0_rdata_q <= {DATA_W{1'b0}};
      m1_rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule
